// File: rtl/framebuffer_pixel_writer.sv
// Framebuffer write stage: accepts 4-bit gray pixels, toggles the write strobe per nibble and
// waits for the strobe echo. Optional ack timeout is built when FB_WRITER_TIMEOUT_EN is defined.
module framebuffer_pixel_writer #(
    parameter int H_PIXELS         = 320,
    parameter int V_PIXELS         = 240,
    parameter int HOLD_CYCLES      = 4,
    parameter int PTR_RESET_CYCLES = 8,
    parameter int TIMEOUT_CYCLES   = 1024,
    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start_in,
    input  logic [3:0]    pixel_in,
    input  logic          pixel_valid_in,
    output logic          pixel_ready_out,
    output logic [XW-1:0] pixel_x_out,
    output logic [YW-1:0] pixel_y_out,
    output logic [3:0]    write_data_out,
    output logic          write_strobe_out,
    output logic          reset_write_ptr_out,
    input  logic          wrote_data_in,
    output logic          busy_out,
    output logic          frame_done_out,
    output logic          error_out,
    output logic [2:0]    dbg_state_out
);

    // Handshake: a pixel transfers on a rising edge where pixel_valid_in && pixel_ready_out.
    // pixel_ready_out is combinational and never depends on pixel_valid_in.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PTR_RST  = 3'd1,
        S_WAIT_PIX = 3'd2,
        S_HOLD     = 3'd3,
        S_ACK      = 3'd4
    } state_t;

    localparam int CMAX = (HOLD_CYCLES > PTR_RESET_CYCLES) ? HOLD_CYCLES : PTR_RESET_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [3:0]      data_q, data_d;
    logic            strobe_q, strobe_d;
    logic            done_q, done_d;
    logic            ack_match;
    logic            tmo_hit;
    logic            ack_ok;

    assign ack_match = (wrote_data_in == strobe_q);
    assign ack_ok    = ack_match || tmo_hit;

`ifdef FB_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    assign tmo_hit = (state_q == S_ACK) && !ack_match && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        err_d = err_q | (tmo_hit && !frame_start_in);
        if ((state_q == S_ACK) && !ack_match && !tmo_hit) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign error_out = err_q;
`else
    // TIMEOUT_CYCLES has no effect in this build; the term below folds to constant 0.
    assign tmo_hit   = 1'b0;
    assign error_out = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_PTR_RST: begin
                x_d = '0;
                y_d = '0;
                if (cnt_q == CW'(PTR_RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_PIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_PIX: begin
                if (pixel_valid_in && pixel_ready_out) begin
                    data_d   = pixel_in;
                    strobe_d = ~strobe_q;
                    cnt_d    = '0;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACK: begin
                if (ack_ok) begin
                    state_d = S_WAIT_PIX;
                    if (x_q == XW'(H_PIXELS - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(V_PIXELS - 1)) begin
                            y_d     = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame restart overrides everything except the nibble/strobe, whose parity must
        // stay in step with the framebuffer echo.
        if (frame_start_in) begin
            state_d = S_PTR_RST;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign pixel_ready_out     = (state_q == S_WAIT_PIX) && !frame_start_in;
    assign pixel_x_out         = x_q;
    assign pixel_y_out         = y_q;
    assign write_data_out      = data_q;
    assign write_strobe_out    = strobe_q;
    assign reset_write_ptr_out = (state_q == S_PTR_RST);
    assign busy_out            = (state_q != S_IDLE);
    assign frame_done_out      = done_q;
    assign dbg_state_out       = state_q;

endmodule

// File: tb/tb_framebuffer_pixel_writer.sv
// Directed bench for framebuffer_pixel_writer: a 320x240 instance and a 4x2 instance, each
// with a framebuffer echo model that returns the strobe one cycle later.
module tb_framebuffer_pixel_writer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_ACK  = 3'd4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // instance a: 320x240
    logic       fs_a, valid_a, echo_a, hold_echo, exp_str_a;
    logic [3:0] pix_a, data_a;
    logic [8:0] x_a;
    logic [7:0] y_a;
    logic       ready_a, strobe_a, ptr_a, busy_a, done_a, err_a;
    logic [2:0] st_a;

    // instance b: 4x2
    logic       fs_b, valid_b, echo_b, exp_str_b;
    logic [3:0] pix_b, data_b;
    logic [1:0] x_b;
    logic [0:0] y_b;
    logic       ready_b, strobe_b, ptr_b, busy_b, done_b, err_b;
    logic [2:0] st_b;

    logic       sel;
    logic       ready, strobe, ptr, busy, done, err;
    logic [3:0] data;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] st;

    logic [3:0] exp_q[$];

    assign ready  = sel ? ready_b  : ready_a;
    assign strobe = sel ? strobe_b : strobe_a;
    assign ptr    = sel ? ptr_b    : ptr_a;
    assign busy   = sel ? busy_b   : busy_a;
    assign done   = sel ? done_b   : done_a;
    assign err    = sel ? err_b    : err_a;
    assign data   = sel ? data_b   : data_a;
    assign x      = sel ? {7'd0, x_b} : x_a;
    assign y      = sel ? {7'd0, y_b} : y_a;
    assign st     = sel ? st_b     : st_a;

    framebuffer_pixel_writer #(
        .H_PIXELS(320), .V_PIXELS(240), .HOLD_CYCLES(4), .PTR_RESET_CYCLES(8), .TIMEOUT_CYCLES(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start_in(fs_a), .pixel_in(pix_a),
        .pixel_valid_in(valid_a), .pixel_ready_out(ready_a), .pixel_x_out(x_a),
        .pixel_y_out(y_a), .write_data_out(data_a), .write_strobe_out(strobe_a),
        .reset_write_ptr_out(ptr_a), .wrote_data_in(echo_a), .busy_out(busy_a),
        .frame_done_out(done_a), .error_out(err_a), .dbg_state_out(st_a)
    );

    framebuffer_pixel_writer #(
        .H_PIXELS(4), .V_PIXELS(2), .HOLD_CYCLES(4), .PTR_RESET_CYCLES(8), .TIMEOUT_CYCLES(16)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start_in(fs_b), .pixel_in(pix_b),
        .pixel_valid_in(valid_b), .pixel_ready_out(ready_b), .pixel_x_out(x_b),
        .pixel_y_out(y_b), .write_data_out(data_b), .write_strobe_out(strobe_b),
        .reset_write_ptr_out(ptr_b), .wrote_data_in(echo_b), .busy_out(busy_b),
        .frame_done_out(done_b), .error_out(err_b), .dbg_state_out(st_b)
    );

    // framebuffer echo model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_a <= 1'b0;
            echo_b <= 1'b0;
        end else begin
            if (!hold_echo) echo_a <= strobe_a;
            echo_b <= strobe_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic fs, input logic v, input logic [3:0] p);
        if (sel) begin
            fs_b = fs; valid_b = v; pix_b = p;
        end else begin
            fs_a = fs; valid_a = v; pix_a = p;
        end
    endtask

    task automatic start_frame();
        drive(1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b0, 1'b0, 4'd0);
    endtask

    task automatic count_ptr(output int n);
        n = 0;
        while (ptr && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    task automatic send_pixel(input logic [3:0] v, output int acc_cyc);
        logic es;
        drive(1'b0, 1'b1, v);
        wait_ready(100);
        acc_cyc = cyc;
        exp_q.push_back(v);
        if (sel) begin
            exp_str_b = ~exp_str_b; es = exp_str_b;
        end else begin
            exp_str_a = ~exp_str_a; es = exp_str_a;
        end
        tick();
        drive(1'b0, 1'b0, 4'd0);
        chk("write_data", {28'd0, data}, {28'd0, exp_q.pop_front()});
        chk("strobe", {31'd0, strobe}, {31'd0, es});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, acc, prev, dn;
        sel = 1'b0; rst_n = 1'b0; hold_echo = 1'b0;
        fs_a = 0; valid_a = 0; pix_a = 0; fs_b = 0; valid_b = 0; pix_b = 0;
        exp_str_a = 1'b0; exp_str_b = 1'b0;
        #22;
        // reset state
        chk("rst_ready", {31'd0, ready_a}, 0);
        chk("rst_x", {23'd0, x_a}, 0);
        chk("rst_y", {24'd0, y_a}, 0);
        chk("rst_data", {28'd0, data_a}, 0);
        chk("rst_strobe", {31'd0, strobe_a}, 0);
        chk("rst_ptr", {31'd0, ptr_a}, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_done", {31'd0, done_a}, 0);
        chk("rst_err", {31'd0, err_a}, 0);
        chk("rst_state", {29'd0, st_a}, {29'd0, ST_IDLE});
        chk("rst_b_busy", {31'd0, busy_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // small 4x2 frame
        sel = 1'b1;
        start_frame();
        count_ptr(n);
        chk("b_ptr_len", n, 8);
        for (int i = 0; i < 8; i++) begin
            wait_ready(100);
            chk("b_x", {23'd0, x}, i % 4);
            chk("b_y", {24'd0, y}, i / 4);
            send_pixel(4'(i + 3), acc);
        end
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) dn++;
            tick();
        end
        chk("b_done_pulses", dn, 1);
        chk("b_busy_after", {31'd0, busy}, 0);
        chk("b_ready_after", {31'd0, ready}, 0);
        chk("b_x_after", {23'd0, x}, 0);
        chk("b_y_after", {24'd0, y}, 0);

        // pointer reset length then ready
        sel = 1'b0;
        start_frame();
        count_ptr(n);
        chk("ptr_len", n, 8);
        chk("ready_after_ptr", {31'd0, ready}, 1);
        chk("busy_wait", {31'd0, busy}, 1);
        chk("x0", {23'd0, x}, 0);

        // stream 0..F, 6-cycle accept spacing
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            send_pixel(4'(i), acc);
            if (i > 0) chk("accept_gap", acc - prev, 6);
            prev = acc;
        end
        wait_ready(100);
        chk("x_after16", {23'd0, x}, 16);
        chk("y_after16", {24'd0, y}, 0);
        chk("strobe_after16", {31'd0, strobe}, 0);

        // frame_start wins over a same-cycle handshake
        drive(1'b1, 1'b1, 4'd5);
        #1;
        chk("fs_ready", {31'd0, ready}, 0);
        tick();
        drive(1'b0, 1'b0, 4'd0);
        chk("fs_ptr", {31'd0, ptr}, 1);
        chk("fs_data_kept", {28'd0, data}, 15);
        chk("fs_strobe_kept", {31'd0, strobe}, 0);
        count_ptr(n);
        chk("fs_ptr_len", n, 8);
        chk("fs_x", {23'd0, x}, 0);
        chk("fs_ready_after", {31'd0, ready}, 1);

        // frame_start during PTR_RST restarts the count
        start_frame();
        tick();
        tick();
        start_frame();
        count_ptr(n);
        chk("restart_ptr_len", n, 8);

        // echo held in ACK
        hold_echo = 1'b1;
        send_pixel(4'd9, acc);
`ifdef FB_WRITER_TIMEOUT_EN
        chk("tmo_err_early", {31'd0, err}, 0);
        wait_ready(100);
        chk("tmo_latency", cyc - acc, 21);
        chk("tmo_err", {31'd0, err}, 1);
        chk("tmo_x", {23'd0, x}, 1);
        hold_echo = 1'b0;
        tick();
        send_pixel(4'd7, acc);
        wait_ready(100);
        chk("tmo_next_x", {23'd0, x}, 2);
        chk("tmo_err_sticky", {31'd0, err}, 1);
`else
        repeat (40) tick();
        chk("hold_ready", {31'd0, ready}, 0);
        chk("hold_state", {29'd0, st}, {29'd0, ST_ACK});
        chk("hold_err", {31'd0, err}, 0);
        hold_echo = 1'b0;
        wait_ready(100);
        chk("hold_x", {23'd0, x}, 1);
`endif

        // async reset in the middle of HOLD
        send_pixel(4'hA, acc);
        tick();
        chk("pre_rst_state", {29'd0, st}, {29'd0, ST_HOLD});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {28'd0, data}, 0);
        chk("mid_rst_strobe", {31'd0, strobe}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_x", {23'd0, x}, 0);
        chk("mid_rst_ready", {31'd0, ready}, 0);
        chk("mid_rst_err", {31'd0, err}, 0);
        exp_str_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_state", {29'd0, st}, {29'd0, ST_IDLE});
        chk("post_rst_ptr", {31'd0, ptr}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
